mvm_layer_ctrl: RTL

Sequencing controller for one fully-connected layer of the streaming network: it accepts an N-element input vector on a valid/ready stream, drives the input-vector memory, weight-ROM address and shared P-lane MAC array through M/P compute rounds, then hands the P accumulated results per round to the output stream. It contains no datapath arithmetic. It instantiates once per layer next to its x-memory, weight ROM and MAC lanes inside the net_* top levels.

---
 rtl/mvm_layer_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mvm_layer_ctrl.sv
// mvm_layer_ctrl: sequencing controller for one fully-connected layer.
// Loads an N-element input vector into x-memory, runs M/P compute rounds
// of N MAC terms on P parallel lanes, then streams the P lane results of
// each round out through a lane select. No datapath arithmetic lives here.
module mvm_layer_ctrl #(
    parameter int M  = 8,                          // layer outputs (rows), multiple of P
    parameter int N  = 4,                          // layer inputs (columns), >= 2
    parameter int P  = 2,                          // parallel MAC lanes, >= 1
    parameter int XW = $clog2(N),                  // x-memory address width
    parameter int WW = $clog2(M*N/P),              // weight-ROM address width
    parameter int SW = (P > 1) ? $clog2(P) : 1     // output lane select width
) (
    input  logic          clk,
    input  logic          reset,         // asynchronous, active-low
    input  logic          input_valid,
    output logic          input_ready,
    output logic          x_we,
    output logic [XW-1:0] x_addr,
    output logic [WW-1:0] w_addr,
    output logic          mac_en,
    output logic          mac_clear,
    output logic [SW-1:0] out_sel,
    output logic          output_valid,
    input  logic          output_ready
);

    // Number of compute rounds and the width of the round counter.
    localparam int R  = M / P;
    localparam int RW = (R > 1) ? $clog2(R) : 1;

    // Terminal counts, sized to the counters they are compared against.
    localparam logic [XW-1:0] K_LAST = XW'(N - 1);
    localparam logic [RW-1:0] R_LAST = RW'(R - 1);
    localparam logic [SW-1:0] S_LAST = SW'(P - 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t        r_state;
    logic [XW-1:0] r_k;       // element index: write address in LOAD, read address in COMPUTE
    logic [RW-1:0] r_r;       // compute round
    logic [SW-1:0] r_s;       // lane being presented in DRAIN
    logic [WW-1:0] r_w;       // weight address, always r*N + k while issuing
    logic          r_tail;    // COMPUTE flush cycle: all N addresses issued, last term in flight
    logic          r_pv;      // an address was issued last cycle, so operands are valid now
    logic          r_first;   // the operands now valid belong to term k==0

    logic w_load;
    logic w_compute;
    logic w_drain;
    logic w_issue;
    logic w_k_last;

    assign w_load    = (r_state == ST_LOAD);
    assign w_compute = (r_state == ST_COMPUTE);
    assign w_drain   = (r_state == ST_DRAIN);
    // Addresses go out on every COMPUTE cycle except the trailing flush cycle.
    assign w_issue   = w_compute && !r_tail;
    assign w_k_last  = (r_k == K_LAST);

    // Controller state, counters and the one-cycle read-latency pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_LOAD;
            r_k     <= '0;
            r_r     <= '0;
            r_s     <= '0;
            r_w     <= '0;
            r_tail  <= 1'b0;
            r_pv    <= 1'b0;
            r_first <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all next-state terms are
            // computed from the values held before this edge, regardless of
            // statement order; blocking = would leak updated counters into
            // later comparisons in the same cycle.
            r_pv    <= w_issue;
            r_first <= w_issue && (r_k == '0);

            case (r_state)
                ST_LOAD: begin
                    if (input_valid) begin
                        if (w_k_last) begin
                            r_k     <= '0;
                            r_r     <= '0;
                            r_state <= ST_COMPUTE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end

                ST_COMPUTE: begin
                    if (!r_tail) begin
                        // Weight address runs continuously across rounds and
                        // returns to 0 after the very last term of the vector.
                        if (w_k_last && (r_r == R_LAST)) begin
                            r_w <= '0;
                        end else begin
                            r_w <= r_w + 1'b1;
                        end
                        if (w_k_last) begin
                            r_k    <= '0;
                            r_tail <= 1'b1;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end else begin
                        // Flush cycle: the last mac_en fires now, results are final next cycle.
                        r_tail  <= 1'b0;
                        r_s     <= '0;
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    if (output_ready) begin
                        if (r_s == S_LAST) begin
                            r_s <= '0;
                            r_k <= '0;
                            if (r_r == R_LAST) begin
                                r_r     <= '0;
                                r_state <= ST_LOAD;
                            end else begin
                                r_r     <= r_r + 1'b1;
                                r_state <= ST_COMPUTE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    // Stream handshakes are decoded from state only, so output_ready never
    // reaches input_ready combinationally; x_we follows input_valid in LOAD.
    assign input_ready  = w_load;
    assign x_we         = w_load && input_valid;
    assign output_valid = w_drain;
    assign out_sel      = r_s;

    // Memory addresses come straight from the counters; MAC controls are
    // registered so they line up with the one-cycle ROM/x-memory read.
    assign x_addr    = r_k;
    assign w_addr    = r_w;
    assign mac_en    = r_pv;
    assign mac_clear = r_first;

endmodule
